// File: rtl/hazard_sequencer.sv
// Hazard and sequencing controller for the 16-bit MIPS pipeline: load-use stalls,
// jump fetch-redirect, taken-branch squash, HALT/resume and a saturating stall counter.
module hazard_sequencer #(
    parameter int          REG_AW  = 4,
    parameter logic [5:0]  OP_LOAD = 6'b010100,
    parameter logic [5:0]  OP_JUMP = 6'b011110,
    parameter logic [5:0]  OP_HALT = 6'b010001,
    parameter int          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [REG_AW-1:0] src_a,
    input  logic [REG_AW-1:0] src_b,
    input  logic              uses_b,
    input  logic [REG_AW-1:0] dst,
    input  logic              branch_taken,
    input  logic              resume,
    output logic              stall,
    output logic              stall_pm,
    output logic              bubble_id,
    output logic              flush_if,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {RUN = 2'd0, JUMP = 2'd1, HALT = 2'd2} state_t;

    state_t            state, state_next;
    logic              load_pending, load_pending_next;
    logic [REG_AW-1:0] load_dst, load_dst_next;
    logic              hazard;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Register 0 is hard-wired zero, so a load into it never blocks a consumer.
    assign hazard = load_pending && (load_dst != '0) &&
                    ((src_a == load_dst) || (uses_b && (src_b == load_dst)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            load_pending <= 1'b0;
            load_dst     <= '0;
            stall_count  <= '0;
        end else begin
            state        <= state_next;
            load_pending <= load_pending_next;
            load_dst     <= load_dst_next;
            if (stall)
                stall_count <= sat_inc(stall_count);
        end
    end

    always_comb begin
        state_next        = state;
        load_pending_next = load_pending;
        load_dst_next     = load_dst;
        if (branch_taken) begin
            state_next = RUN;
        end else begin
            case (state)
                HALT:    if (resume) state_next = RUN;
                JUMP:    state_next = RUN;
                default: begin
                    if (!hazard) begin
                        if (op == OP_HALT)      state_next = HALT;
                        else if (op == OP_JUMP) state_next = JUMP;
                    end
                end
            endcase
        end
        // A load is only remembered once it actually leaves ID.
        if (bubble_id) begin
            load_pending_next = 1'b0;
        end else if (!stall_pm) begin
            load_pending_next = (op == OP_LOAD);
            if (op == OP_LOAD) load_dst_next = dst;
        end
    end

    always_comb begin
        stall     = 1'b0;
        stall_pm  = 1'b0;
        bubble_id = 1'b0;
        flush_if  = 1'b0;
        halted    = 1'b0;
        if (!reset) begin
            if (branch_taken) begin
                flush_if  = 1'b1;
                bubble_id = 1'b1;
            end else begin
                case (state)
                    HALT: begin
                        stall     = 1'b1;
                        stall_pm  = 1'b1;
                        bubble_id = 1'b1;
                        halted    = 1'b1;
                    end
                    JUMP: flush_if = 1'b1;
                    default: begin
                        if (hazard) begin
                            stall     = 1'b1;
                            stall_pm  = 1'b1;
                            bubble_id = 1'b1;
                        end else if (op == OP_HALT) begin
                            stall    = 1'b1;
                            stall_pm = 1'b1;
                        end else if (op == OP_JUMP) begin
                            flush_if = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed vector table, randomized run against a
// rule-level model, and stall-counter saturation.
module tb_hazard_sequencer;

    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] LD  = 6'b010100;
    localparam logic [5:0] JP  = 6'b011110;
    localparam logic [5:0] HT  = 6'b010001;

    // Control bundle order: {stall, stall_pm, bubble_id, flush_if, halted}
    localparam logic [4:0] C0   = 5'b00000;
    localparam logic [4:0] CSTL = 5'b11100;
    localparam logic [4:0] CHLT = 5'b11000;
    localparam logic [4:0] CHS  = 5'b11101;
    localparam logic [4:0] CFL  = 5'b00010;
    localparam logic [4:0] CBR  = 5'b00110;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [3:0]  a, b;
        logic        ub;
        logic [3:0]  dst;
        logic        br, res;
        logic [4:0]  ctl;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, uses_b, branch_taken, resume;
    logic [5:0]  op;
    logic [3:0]  src_a, src_b, dst;
    logic        stall, stall_pm, bubble_id, flush_if, halted;
    logic [15:0] stall_count;

    int nvec = 0;
    int nmis = 0;

    // Reference model state: halt flag, pending extra fetch kill, last advanced load.
    bit         m_halt, m_jk, m_ldv;
    logic [3:0] m_ldr;
    int         m_cnt;

    hazard_sequencer dut (
        .clk(clk), .reset(reset), .op(op), .src_a(src_a), .src_b(src_b),
        .uses_b(uses_b), .dst(dst), .branch_taken(branch_taken), .resume(resume),
        .stall(stall), .stall_pm(stall_pm), .bubble_id(bubble_id),
        .flush_if(flush_if), .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [5:0] o, input logic [3:0] a,
                                input logic [3:0] b, input logic ub, input logic [3:0] d,
                                input logic br, input logic res, input logic [4:0] ctl,
                                input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.op = o; v.a = a; v.b = b; v.ub = ub; v.dst = d;
        v.br = br; v.res = res; v.ctl = ctl; v.cnt = cnt;
        return v;
    endfunction

    task automatic model(input vec_t v, output logic [4:0] ctl);
        bit hz;
        ctl = C0;
        if (v.rst) begin
            m_halt = 0; m_jk = 0; m_ldv = 0; m_ldr = '0; m_cnt = 0;
            return;
        end
        hz = m_ldv && (m_ldr != 0) && ((v.a == m_ldr) || (v.ub && (v.b == m_ldr)));
        if (v.br) begin
            ctl = CBR; m_halt = 0; m_jk = 0; m_ldv = 0;
        end else if (m_halt) begin
            ctl = CHS; m_ldv = 0; m_halt = !v.res;
        end else if (m_jk) begin
            ctl = CFL; m_jk = 0;
            m_ldv = (v.op == LD);
            if (v.op == LD) m_ldr = v.dst;
        end else if (hz) begin
            ctl = CSTL; m_ldv = 0;
        end else if (v.op == HT) begin
            ctl = CHLT; m_halt = 1;
        end else if (v.op == JP) begin
            ctl = CFL; m_jk = 1; m_ldv = 0;
        end else begin
            m_ldv = (v.op == LD);
            if (v.op == LD) m_ldr = v.dst;
        end
        if (ctl[4] && m_cnt < 65535) m_cnt++;
    endtask

    task automatic step(input vec_t v, input bit use_tbl, input bit do_check, input string name);
        logic [4:0]  mctl;
        logic [4:0]  ectl;
        logic [15:0] ecnt;
        logic [4:0]  got;
        reset = v.rst; op = v.op; src_a = v.a; src_b = v.b; uses_b = v.ub;
        dst = v.dst; branch_taken = v.br; resume = v.res;
        @(negedge clk);
        ecnt = use_tbl ? v.cnt : 16'(m_cnt);
        model(v, mctl);
        ectl = use_tbl ? v.ctl : mctl;
        got  = {stall, stall_pm, bubble_id, flush_if, halted};
        if (do_check) begin
            nvec++;
            if (got !== ectl || stall_count !== ecnt) begin
                nmis++;
                $display("FAIL %s: got ctl=%b cnt=%0d, required ctl=%b cnt=%0d (t=%0t)",
                         name, got, stall_count, ectl, ecnt, $time);
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        // rst, op, a, b, ub, dst, br, res, ctl, cnt
        tbl.push_back(mk(1, HT,  0, 0, 0, 0, 1, 0, C0,   0));
        tbl.push_back(mk(1, HT,  0, 0, 0, 0, 1, 0, C0,   0));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   0));
        tbl.push_back(mk(0, LD,  1, 0, 0, 3, 0, 0, C0,   0));
        tbl.push_back(mk(0, NOP, 3, 0, 0, 0, 0, 0, CSTL, 0));
        tbl.push_back(mk(0, NOP, 3, 0, 0, 0, 0, 0, C0,   1));
        tbl.push_back(mk(0, LD,  0, 0, 0, 0, 0, 0, C0,   1));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   1));
        tbl.push_back(mk(0, LD,  1, 0, 0, 5, 0, 0, C0,   1));
        tbl.push_back(mk(0, NOP, 2, 5, 0, 0, 0, 0, C0,   1));
        tbl.push_back(mk(0, LD,  1, 0, 0, 5, 0, 0, C0,   1));
        tbl.push_back(mk(0, NOP, 2, 5, 1, 0, 0, 0, CSTL, 1));
        tbl.push_back(mk(0, NOP, 2, 5, 1, 0, 0, 0, C0,   2));
        tbl.push_back(mk(0, JP,  0, 0, 0, 0, 0, 0, CFL,  2));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, CFL,  2));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   2));
        tbl.push_back(mk(0, HT,  0, 0, 0, 0, 0, 0, CHLT, 2));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, CHS,  3));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, CHS,  4));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, CHS,  5));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 1, CHS,  6));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   7));
        tbl.push_back(mk(0, HT,  0, 0, 0, 0, 0, 0, CHLT, 7));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 1, 0, CBR,  8));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   8));
        tbl.push_back(mk(0, JP,  0, 0, 0, 0, 1, 0, CBR,  8));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   8));
        tbl.push_back(mk(0, LD,  1, 0, 0, 4, 0, 0, C0,   8));
        tbl.push_back(mk(0, NOP, 4, 0, 0, 0, 1, 0, CBR,  8));
        tbl.push_back(mk(0, NOP, 4, 0, 0, 0, 0, 0, C0,   8));
        tbl.push_back(mk(0, HT,  0, 0, 0, 0, 1, 0, CBR,  8));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   8));
        tbl.push_back(mk(0, HT,  0, 0, 0, 0, 0, 0, CHLT, 8));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, CHS,  9));
        tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 0, C0,  10));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,   0));

        reset = 1'b1; op = HT; src_a = '0; src_b = '0; uses_b = 1'b0; dst = '0;
        branch_taken = 1'b1; resume = 1'b0;
        m_halt = 0; m_jk = 0; m_ldv = 0; m_ldr = '0; m_cnt = 0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], 1, 1, $sformatf("table[%0d]", i));

        // Randomized traffic on a small register set so hazards occur often.
        step(mk(1, NOP, 0, 0, 0, 0, 0, 0, C0, 0), 0, 1, "rand_reset");
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            rv.op  = (r < 3) ? LD : (r == 3) ? JP : (r == 4) ? HT : 6'($urandom_range(0, 63));
            rv.a   = 4'($urandom_range(0, 3));
            rv.b   = 4'($urandom_range(0, 3));
            rv.ub  = 1'($urandom_range(0, 1));
            rv.dst = 4'($urandom_range(0, 3));
            rv.br  = ($urandom_range(0, 7) == 0);
            rv.res = ($urandom_range(0, 3) == 0);
            rv.rst = ($urandom_range(0, 99) == 0);
            rv.ctl = C0;
            rv.cnt = '0;
            step(rv, 0, 1, $sformatf("random[%0d]", i));
        end

        // Counter saturation: park in HALT for more than 2^16 stall cycles.
        step(mk(1, NOP, 0, 0, 0, 0, 0, 0, C0, 0), 0, 1, "sat_reset");
        step(mk(0, HT, 0, 0, 0, 0, 0, 0, C0, 0), 0, 1, "sat_enter");
        for (int i = 0; i < 65538; i++)
            step(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0, 0), 0, 0, "");
        step(mk(0, NOP, 0, 0, 0, 0, 0, 0, CHS, 16'hFFFF), 1, 1, "sat_hold0");
        step(mk(0, NOP, 0, 0, 0, 0, 0, 0, CHS, 16'hFFFF), 1, 1, "sat_hold1");
        step(mk(0, NOP, 0, 0, 0, 0, 0, 1, CHS, 16'hFFFF), 1, 1, "sat_resume");
        step(mk(0, NOP, 0, 0, 0, 0, 0, 0, C0,  16'hFFFF), 1, 1, "sat_run");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
